// File: rtl/display_refresh.sv
// display_refresh: four-digit 7-segment refresh scanner with frame-synchronised digit updates
module display_refresh #(
  parameter int DIV = 50000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Enable,
  input  logic        Update,
  input  logic [15:0] Digits,
  input  logic [3:0]  Blank,
  output logic [1:0]  Sel,
  output logic        Tick,
  output logic [6:0]  Seg,
  output logic        Busy
);
  localparam logic [15:0] LAST = 16'(DIV - 1);
  logic [15:0] p;
  logic [15:0] staging;
  logic [15:0] shadow;
  logic        frame;
  logic [3:0]  code;
  assign Tick  = Enable && (p == LAST);
  assign frame = Tick && (Sel == 2'd3);
  assign code  = shadow[{Sel, 2'b00} +: 4];
  // Prescaler, digit scan and the staging/shadow handoff that only swaps digits between frames
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      p       <= '0;
      Sel     <= '0;
      staging <= '0;
      shadow  <= '0;
      Busy    <= 1'b0;
    end else begin
      if (Enable) p <= (p == LAST) ? '0 : p + 16'd1;
      if (Tick) Sel <= Sel + 2'd1;
      if (Update) staging <= Digits;
      if (frame) begin
        if (Update) shadow <= Digits;
        else if (Busy) shadow <= staging;
        Busy <= 1'b0;
      end else if (Update) begin
        Busy <= 1'b1;
      end
    end
  end
  // Active-low segment decode of the selected digit; blanked or non-decimal codes stay dark
  always_comb begin
    Seg = 7'b1111111;
    if (!Blank[Sel]) begin
      case (code)
        4'd0: Seg = 7'b1000000;
        4'd1: Seg = 7'b1111001;
        4'd2: Seg = 7'b0100100;
        4'd3: Seg = 7'b0110000;
        4'd4: Seg = 7'b0011001;
        4'd5: Seg = 7'b0010010;
        4'd6: Seg = 7'b0000010;
        4'd7: Seg = 7'b1111000;
        4'd8: Seg = 7'b0000000;
        4'd9: Seg = 7'b0010000;
        default: Seg = 7'b1111111;
      endcase
    end
  end
endmodule

// File: tb/tb_display_refresh.sv
// tb_display_refresh: directed checks of scan timing, frame-synchronised updates, decode and reset
module tb_display_refresh;
  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Enable = 1'b0;
  logic        Update = 1'b0;
  logic [15:0] Digits = '0;
  logic [3:0]  Blank = '0;
  logic [1:0]  Sel;
  logic        Tick;
  logic [6:0]  Seg;
  logic        Busy;
  int vectors = 0;
  int errors = 0;

  display_refresh #(.DIV(4)) dut (
    .Clk(Clk), .Reset(Reset), .Enable(Enable), .Update(Update), .Digits(Digits),
    .Blank(Blank), .Sel(Sel), .Tick(Tick), .Seg(Seg), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge Clk);
      @(negedge Clk);
    end
  endtask

  task automatic test_reset;
    @(negedge Clk);
    #1;
    vectors++;
    if (Sel !== 2'd0 || Busy !== 1'b0 || Tick !== 1'b0 || Seg !== 7'b1000000) begin
      errors++;
      $display("FAIL reset_state got sel=%0d busy=%b tick=%b seg=%b want 0 0 0 1000000", Sel, Busy, Tick, Seg);
    end
    Blank = 4'b0001;
    #1;
    vectors++;
    if (Seg !== 7'b1111111) begin
      errors++;
      $display("FAIL reset_blank0 got seg=%b want 1111111", Seg);
    end
    Blank = 4'b0000;
    @(negedge Clk);
    Reset = 1'b0;
    Enable = 1'b1;
  endtask

  task automatic test_prescaler;
    for (int k = 1; k <= 16; k++) begin
      vectors++;
      if (Tick !== ((k % 4) == 0)) begin
        errors++;
        $display("FAIL prescaler_tick cycle=%0d got %b want %b", k, Tick, (k % 4) == 0);
      end
      step(1);
      vectors++;
      if (Sel !== 2'((k / 4) % 4)) begin
        errors++;
        $display("FAIL prescaler_sel cycle=%0d got %0d want %0d", k, Sel, (k / 4) % 4);
      end
    end
  endtask

  task automatic test_update;
    step(5);
    Update = 1'b1;
    Digits = 16'h4321;
    step(1);
    Update = 1'b0;
    Digits = 16'h0000;
    for (int k = 6; k <= 15; k++) begin
      vectors++;
      if (Busy !== 1'b1 || Seg !== 7'b1000000) begin
        errors++;
        $display("FAIL update_pending after_edge=%0d got busy=%b seg=%b want 1 1000000", k, Busy, Seg);
      end
      if (k < 15) step(1);
    end
    step(1);
    vectors++;
    if (Busy !== 1'b0 || Sel !== 2'd0 || Seg !== 7'b1111001) begin
      errors++;
      $display("FAIL update_applied got busy=%b sel=%0d seg=%b want 0 0 1111001", Busy, Sel, Seg);
    end
    step(4);
    vectors++;
    if (Seg !== 7'b0100100) begin
      errors++;
      $display("FAIL update_digit1 got %b want 0100100", Seg);
    end
    step(4);
    vectors++;
    if (Seg !== 7'b0110000) begin
      errors++;
      $display("FAIL update_digit2 got %b want 0110000", Seg);
    end
    step(4);
    vectors++;
    if (Seg !== 7'b0011001) begin
      errors++;
      $display("FAIL update_digit3 got %b want 0011001", Seg);
    end
    step(4);
  endtask

  task automatic test_collision;
    step(15);
    vectors++;
    if (Tick !== 1'b1 || Sel !== 2'd3) begin
      errors++;
      $display("FAIL collision_boundary got tick=%b sel=%0d want 1 3", Tick, Sel);
    end
    Update = 1'b1;
    Digits = 16'h8888;
    step(1);
    Update = 1'b0;
    Digits = 16'h0000;
    vectors++;
    if (Busy !== 1'b0) begin
      errors++;
      $display("FAIL collision_busy got %b want 0", Busy);
    end
    for (int s = 0; s < 4; s++) begin
      vectors++;
      if (Sel !== 2'(s) || Seg !== 7'b0000000) begin
        errors++;
        $display("FAIL collision_seg sel got %0d want %0d seg got %b want 0000000", Sel, s, Seg);
      end
      step(4);
    end
  endtask

  task automatic test_freeze;
    step(2);
    Enable = 1'b0;
    Update = 1'b1;
    Digits = 16'h1111;
    step(1);
    Update = 1'b0;
    vectors++;
    if (Busy !== 1'b1 || Seg !== 7'b0000000) begin
      errors++;
      $display("FAIL freeze_capture got busy=%b seg=%b want 1 0000000", Busy, Seg);
    end
    for (int k = 0; k < 9; k++) begin
      vectors++;
      if (Tick !== 1'b0 || Sel !== 2'd0) begin
        errors++;
        $display("FAIL freeze_hold k=%0d got tick=%b sel=%0d want 0 0", k, Tick, Sel);
      end
      step(1);
    end
    Enable = 1'b1;
    #1;
    vectors++;
    if (Tick !== 1'b0) begin
      errors++;
      $display("FAIL freeze_resume_early got tick=%b want 0", Tick);
    end
    step(1);
    vectors++;
    if (Tick !== 1'b1 || Sel !== 2'd0) begin
      errors++;
      $display("FAIL freeze_resume_tick got tick=%b sel=%0d want 1 0", Tick, Sel);
    end
    step(12);
    vectors++;
    if (Busy !== 1'b1 || Tick !== 1'b1 || Sel !== 2'd3 || Seg !== 7'b0000000) begin
      errors++;
      $display("FAIL freeze_preboundary got busy=%b tick=%b sel=%0d seg=%b want 1 1 3 0000000", Busy, Tick, Sel, Seg);
    end
    step(1);
    vectors++;
    if (Busy !== 1'b0 || Seg !== 7'b1111001) begin
      errors++;
      $display("FAIL freeze_applied got busy=%b seg=%b want 0 1111001", Busy, Seg);
    end
  endtask

  task automatic test_back_to_back;
    Update = 1'b1;
    Digits = 16'h5555;
    step(1);
    Digits = 16'h6657;
    step(1);
    Update = 1'b0;
    Digits = 16'h0000;
    vectors++;
    if (Busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_busy got %b want 1", Busy);
    end
    step(14);
    vectors++;
    if (Sel !== 2'd0 || Seg !== 7'b1111000) begin
      errors++;
      $display("FAIL b2b_digit0 got sel=%0d seg=%b want 0 1111000", Sel, Seg);
    end
    step(4);
    vectors++;
    if (Seg !== 7'b0010010) begin
      errors++;
      $display("FAIL b2b_digit1 got %b want 0010010", Seg);
    end
    step(4);
    vectors++;
    if (Seg !== 7'b0000010) begin
      errors++;
      $display("FAIL b2b_digit2 got %b want 0000010", Seg);
    end
    step(8);
  endtask

  task automatic test_blank;
    logic [6:0] exp [4];
    exp[0] = 7'b1111111;
    exp[1] = 7'b1111111;
    exp[2] = 7'b0010000;
    exp[3] = 7'b1111111;
    Update = 1'b1;
    Digits = 16'hF9A0;
    step(1);
    Update = 1'b0;
    Digits = 16'h0000;
    step(15);
    vectors++;
    if (Seg !== 7'b1000000) begin
      errors++;
      $display("FAIL blank_off_digit0 got %b want 1000000", Seg);
    end
    Blank = 4'b0001;
    #1;
    for (int s = 0; s < 4; s++) begin
      vectors++;
      if (Sel !== 2'(s) || Seg !== exp[s]) begin
        errors++;
        $display("FAIL blank_codes sel got %0d want %0d seg got %b want %b", Sel, s, Seg, exp[s]);
      end
      step(4);
    end
    Blank = 4'b0000;
  endtask

  task automatic test_async_reset;
    Update = 1'b1;
    Digits = 16'h8765;
    step(1);
    Update = 1'b0;
    step(7);
    vectors++;
    if (Sel !== 2'd2 || Busy !== 1'b1) begin
      errors++;
      $display("FAIL areset_setup got sel=%0d busy=%b want 2 1", Sel, Busy);
    end
    #2;
    Reset = 1'b1;
    #1;
    vectors++;
    if (Sel !== 2'd0 || Busy !== 1'b0 || Tick !== 1'b0 || Seg !== 7'b1000000) begin
      errors++;
      $display("FAIL areset_immediate got sel=%0d busy=%b tick=%b seg=%b want 0 0 0 1000000", Sel, Busy, Tick, Seg);
    end
    @(negedge Clk);
    Reset = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      vectors++;
      if (Tick !== (k == 4)) begin
        errors++;
        $display("FAIL areset_first_tick cycle=%0d got %b want %b", k, Tick, k == 4);
      end
      step(1);
    end
    step(12);
    vectors++;
    if (Busy !== 1'b0 || Sel !== 2'd0 || Seg !== 7'b1000000) begin
      errors++;
      $display("FAIL areset_discard got busy=%b sel=%0d seg=%b want 0 0 1000000", Busy, Sel, Seg);
    end
  endtask

  initial begin
    test_reset();
    test_prescaler();
    test_update();
    test_collision();
    test_freeze();
    test_back_to_back();
    test_blank();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/display_refresh.md
DISPLAY_REFRESH -- requirements
Module: display_refresh

Interface
REQ-001 SHALL have parameter DIV, default 50000, meaning clock cycles per digit slot; legal range 2..65535.
REQ-002 SHALL have port Clk  input  1  single system clock; all state updates on rising edge.
REQ-003 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port Enable  input  1  high = refresh advances; low = freeze.
REQ-005 SHALL have port Update  input  1  one-cycle strobe requesting a new digit set.
REQ-006 SHALL have port Digits  input  16  four 4-bit codes; Digits[4i+3:4i] = digit i.
REQ-007 SHALL have port Blank  input  4  Blank[i] high forces digit i dark.
REQ-008 SHALL have port Sel  output  2  active digit index; drives the downstream display scheduler.
REQ-009 SHALL have port Tick  output  1  one-cycle pulse marking a digit-slot boundary.
REQ-010 SHALL have port Seg  output  7  active-low segments, Seg[6:0] = {g,f,e,d,c,b,a}, for digit Sel.
REQ-011 SHALL have port Busy  output  1  high while an accepted Update awaits a frame boundary.

Function
REQ-012 Prescaler SHALL be a 16-bit counter P: if Enable, P <= (P == DIV-1) ? 0 : P+1; if not Enable, P holds.
REQ-013 Tick SHALL be combinational: Tick = Enable AND (P == DIV-1); Tick is 0 whenever Enable is 0.
REQ-014 On every edge with Tick = 1, Sel SHALL advance 0->1->2->3->0, wrapping modulo 4; otherwise Sel holds.
REQ-015 Sel SHALL therefore change once every DIV enabled cycles; a full frame is 4*DIV enabled cycles.
REQ-016 Frame boundary SHALL be defined as an edge with Tick = 1 and Sel == 3.
REQ-017 On an edge with Update = 1, Digits SHALL be captured into a 16-bit staging register, and Busy SHALL be set.
REQ-018 A later Update while Busy SHALL overwrite staging; last write wins; Busy stays 1.
REQ-019 At a frame boundary with Busy = 1, the shadow register SHALL load staging and Busy SHALL clear.
REQ-020 If Update = 1 on a frame-boundary edge, shadow SHALL load Digits directly (bypass), staging SHALL load Digits, and Busy SHALL end 0.
REQ-021 Shadow SHALL never change except at a frame boundary or reset, so no partially updated frame is displayed.
REQ-022 Seg SHALL be combinational from registered Sel, shadow and Blank; it changes only on Clk edges or Blank/Reset changes.
REQ-023 Decode SHALL map code to Seg: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-024 Codes 10..15 SHALL produce 1111111 (dark).
REQ-025 If Blank[Sel] = 1, Seg SHALL be 1111111 regardless of code.
REQ-026 Enable = 0 SHALL freeze P and Sel but SHALL NOT block Update capture.
REQ-027 Enable = 0 SHALL also block frame-boundary shadow loads, since Tick is 0.

Reset
REQ-028 On Reset assertion, outputs SHALL take values immediately without waiting for Clk.
REQ-029 On Reset, P, Sel, staging, shadow and Busy SHALL be 0; Tick SHALL be 0; Seg SHALL be 1000000 unless Blank[0] = 1.
REQ-030 Reset asserted mid-frame or with Busy = 1 SHALL discard the pending update.
REQ-031 After Reset deasserts, the first Tick SHALL occur DIV enabled cycles later.

Verification
REQ-032 Scenario, prescaler: DIV=4, Enable=1 from reset -> Tick high on cycles 4, 8, 12, 16; Sel = 1, 2, 3, 0 after each.
REQ-033 Scenario, frame-synchronised update: DIV=4, Update with Digits=16'h4321 at cycle 6 -> Busy high from cycle 7 until the edge after cycle 16; Seg for Sel=0 becomes 1111001 only after that edge.
REQ-034 Scenario, collision: Update with Digits=16'h8888 on the frame-boundary edge -> Busy stays 0; Seg = 0000000 for all Sel in the next frame.
REQ-035 Scenario, freeze: Enable=0 for 10 cycles at P=2 -> P, Sel and Tick constant (Tick 0); Enable=1 -> Tick after 1 more cycle.
REQ-036 Scenario, blanking and codes: shadow=16'hF9A0, Blank=4'b0001 -> Sel 0,1,2,3 give 1111111, 1111111, 0010000, 1111111.
REQ-037 Scenario, asynchronous reset: Reset pulse mid-cycle with Busy=1, Sel=2 -> Sel=0, Busy=0, Seg=1000000 before the next Clk edge.
